// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad front-end: key codes, operating modes
// and controller FSM states.
package teclado_pkg;

  localparam logic [4:0] T_0    = 5'd0;
  localparam logic [4:0] T_1    = 5'd1;
  localparam logic [4:0] T_2    = 5'd2;
  localparam logic [4:0] T_3    = 5'd3;
  localparam logic [4:0] T_4    = 5'd4;
  localparam logic [4:0] T_5    = 5'd5;
  localparam logic [4:0] T_6    = 5'd6;
  localparam logic [4:0] T_7    = 5'd7;
  localparam logic [4:0] T_8    = 5'd8;
  localparam logic [4:0] T_9    = 5'd9;
  localparam logic [4:0] T_A    = 5'd10;
  localparam logic [4:0] T_B    = 5'd11;
  localparam logic [4:0] T_C    = 5'd12;
  localparam logic [4:0] T_D    = 5'd13;
  localparam logic [4:0] T_ASTE = 5'd14;
  localparam logic [4:0] T_HASH = 5'd15;
  localparam logic [4:0] T_NULL = 5'd31;

  typedef enum logic {
    CRON = 1'b0,
    CALC = 1'b1
  } modos_t;

  typedef enum logic [1:0] {
    S_CRON   = 2'd0,
    S_CALC   = 2'd1,
    S_ESPERA = 2'd2
  } estado_t;

  // Only 0..15 are real keys; 16..30 are treated as noise and T_NULL as idle.
  function automatic logic codigo_valido(input logic [4:0] codigo);
    return codigo <= T_HASH;
  endfunction

  // Mode-switch keys depend on the mode currently active.
  function automatic logic tecla_troca(input estado_t estado, input logic [4:0] codigo);
    return ((estado == S_CRON) && ((codigo == T_HASH) || (codigo == T_ASTE))) ||
           ((estado == S_CALC) && (codigo == T_D));
  endfunction

endpackage

// File: rtl/controle_teclado_if.sv
// Keypad input plus the two consumer handshakes (stopwatch and calculator).
interface controle_teclado_if;
  logic [4:0] key;
  logic       pronto_cron;
  logic       pronto_calc;
  logic [4:0] tecla_cron;
  logic       valido_cron;
  logic [4:0] tecla_calc;
  logic       valido_calc;
  logic       modo_atual;
  logic       descarte;

  modport master (
    input  key, pronto_cron, pronto_calc,
    output tecla_cron, valido_cron, tecla_calc, valido_calc, modo_atual, descarte
  );

  modport slave (
    output key, pronto_cron, pronto_calc,
    input  tecla_cron, valido_cron, tecla_calc, valido_calc, modo_atual, descarte
  );
endinterface

// File: rtl/debounce_tecla.sv
// Keypad synchroniser, debouncer and press-event generator.
// Auto-repeat strobes are generated only when TECLADO_REPEAT_EN is defined.
module debounce_tecla
  import teclado_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int REPEAT_MS   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key,
  output logic [4:0] tecla_deb,
  output logic       evento,
  output logic       evento_rep,
  output logic [4:0] evento_tecla
);

  localparam int N_SYNC = 2;
  localparam int CNT_W  = $clog2(DEBOUNCE_MS + 1);

  genvar gi;

  logic [4:0]       sincronizado;
  logic [4:0]       candidato_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [4:0]       deb_reg;
  logic [4:0]       deb_ant_reg;

  generate
    for (gi = 0; gi < N_SYNC; gi++) begin : g_sync
      logic [4:0] q_reg;
      if (gi == 0) begin : g_in
        always_ff @(posedge clk or posedge rst) begin
          if (rst) q_reg <= T_NULL;
          else     q_reg <= key;
        end
      end else begin : g_enc
        always_ff @(posedge clk or posedge rst) begin
          if (rst) q_reg <= T_NULL;
          else     q_reg <= g_sync[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign sincronizado = g_sync[N_SYNC-1].q_reg;

  // Counter saturates at DEBOUNCE_MS; the debounced code moves on the edge it gets there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candidato_reg <= T_NULL;
      cnt_reg       <= '0;
      deb_reg       <= T_NULL;
      deb_ant_reg   <= T_NULL;
    end else begin
      deb_ant_reg <= deb_reg;
      if (sincronizado != candidato_reg) begin
        candidato_reg <= sincronizado;
        cnt_reg       <= '0;
      end else if (cnt_reg != CNT_W'(DEBOUNCE_MS)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(DEBOUNCE_MS - 1))
          deb_reg <= candidato_reg;
      end
    end
  end

  assign tecla_deb    = deb_reg;
  assign evento_tecla = deb_reg;
  assign evento       = (deb_reg != deb_ant_reg) && codigo_valido(deb_reg);

`ifdef TECLADO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_MS + 1);

  logic [REP_W-1:0] rep_cnt_reg;
  logic             segurada;

  assign segurada   = codigo_valido(deb_reg) && (deb_reg == deb_ant_reg);
  assign evento_rep = segurada && (rep_cnt_reg == REP_W'(REPEAT_MS));

  // rep_cnt_reg holds the number of cycles since the last press or repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      rep_cnt_reg <= '0;
    else if (evento || evento_rep) rep_cnt_reg <= REP_W'(1);
    else if (segurada)            rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
    else                          rep_cnt_reg <= '0;
  end
`else
  // Repeat disabled: constant-zero strobe (the compare is false for any legal period).
  assign evento_rep = (REPEAT_MS < 0);
`endif

endmodule

// File: rtl/controle_teclado.sv
// Keypad front-end: mode FSM and per-consumer single-entry handshake registers.
// Optional auto-repeat of held keys is enabled with TECLADO_REPEAT_EN.
module controle_teclado
  import teclado_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int REPEAT_MS   = 500
) (
  input  logic               clk,
  input  logic               rst,
  controle_teclado_if.master bus
);

  logic [4:0] tecla_deb;
  logic       evento;
  logic       evento_rep;
  logic [4:0] evento_tecla;

  debounce_tecla #(
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .REPEAT_MS   (REPEAT_MS)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .key          (bus.key),
    .tecla_deb    (tecla_deb),
    .evento       (evento),
    .evento_rep   (evento_rep),
    .evento_tecla (evento_tecla)
  );

  estado_t    estado_reg, estado_next;
  modos_t     modo_reg, modo_next;
  modos_t     destino_reg, destino_next;
  logic       vcron_reg, vcron_next;
  logic [4:0] tcron_reg, tcron_next;
  logic       vcalc_reg, vcalc_next;
  logic [4:0] tcalc_reg, tcalc_next;
  logic       descarte_reg, descarte_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_reg   <= S_CRON;
      modo_reg     <= CRON;
      destino_reg  <= CRON;
      vcron_reg    <= 1'b0;
      tcron_reg    <= T_NULL;
      vcalc_reg    <= 1'b0;
      tcalc_reg    <= T_NULL;
      descarte_reg <= 1'b0;
    end else begin
      estado_reg   <= estado_next;
      modo_reg     <= modo_next;
      destino_reg  <= destino_next;
      vcron_reg    <= vcron_next;
      tcron_reg    <= tcron_next;
      vcalc_reg    <= vcalc_next;
      tcalc_reg    <= tcalc_next;
      descarte_reg <= descarte_next;
    end
  end

  logic ev_any;
  logic troca;
  logic livre_cron, livre_calc;

  assign ev_any     = evento || evento_rep;
  assign troca      = tecla_troca(estado_reg, evento_tecla);
  // A slot is free if empty or if its handshake completes on this edge.
  assign livre_cron = !vcron_reg || bus.pronto_cron;
  assign livre_calc = !vcalc_reg || bus.pronto_calc;

  always_comb begin
    estado_next   = estado_reg;
    modo_next     = modo_reg;
    destino_next  = destino_reg;
    vcron_next    = vcron_reg;
    tcron_next    = tcron_reg;
    vcalc_next    = vcalc_reg;
    tcalc_next    = tcalc_reg;
    descarte_next = 1'b0;

    if (vcron_reg && bus.pronto_cron) begin
      vcron_next = 1'b0;
      tcron_next = T_NULL;
    end
    if (vcalc_reg && bus.pronto_calc) begin
      vcalc_next = 1'b0;
      tcalc_next = T_NULL;
    end

    case (estado_reg)
      S_CRON: begin
        if (evento && troca) begin
          // Switch keys flush whatever the stopwatch has not yet taken.
          descarte_next = vcron_reg && !bus.pronto_cron;
          vcron_next    = 1'b0;
          tcron_next    = T_NULL;
          destino_next  = CALC;
          estado_next   = S_ESPERA;
        end else if (ev_any && !troca) begin
          if (livre_cron) begin
            vcron_next = 1'b1;
            tcron_next = evento_tecla;
          end else begin
            descarte_next = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (evento && troca) begin
          descarte_next = vcalc_reg && !bus.pronto_calc;
          vcalc_next    = 1'b0;
          tcalc_next    = T_NULL;
          destino_next  = CRON;
          estado_next   = S_ESPERA;
        end else if (ev_any && !troca) begin
          if (livre_calc) begin
            vcalc_next = 1'b1;
            tcalc_next = evento_tecla;
          end else begin
            descarte_next = 1'b1;
          end
        end
      end
      S_ESPERA: begin
        // Stay here until the switch key is released so it never leaks as a press.
        if (tecla_deb == T_NULL) begin
          modo_next   = destino_reg;
          estado_next = (destino_reg == CALC) ? S_CALC : S_CRON;
        end
      end
      default: begin
        estado_next = S_CRON;
      end
    endcase
  end

  assign bus.tecla_cron  = tcron_reg;
  assign bus.valido_cron = vcron_reg;
  assign bus.tecla_calc  = tcalc_reg;
  assign bus.valido_calc = vcalc_reg;
  assign bus.modo_atual  = modo_reg;
  assign bus.descarte    = descarte_reg;

endmodule
